fifo_scoreboard_param: RTL and testbench



---
 rtl/fifo_scoreboard_param.sv | 163 ++++++++++++++++
 tb/tb_fifo_scoreboard_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_scoreboard_param.sv
// Reference-model scoreboard for single-clock FIFOs: mirrors accepted writes,
// checks read data and full/empty flags, and keeps sticky error status.
module fifo_scoreboard_param #(
    parameter int DATA_W      = 4,
    parameter int DEPTH       = 4,
    parameter int RD_LAT      = 1,
    parameter int CHECK_FLAGS = 1,
    parameter int STOP_ON_ERR = 0,
    parameter int CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vld_in,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         vld_out,
    input  logic [DATA_W-1:0]            data_out,
    input  logic                         full_in,
    input  logic                         empty_in,
    input  logic                         clr_err,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err_overflow,
    output logic                         err_underflow,
    output logic                         err_data,
    output logic                         err_flag,
    output logic [CNT_W-1:0]             err_count,
    output logic [DATA_W-1:0]            exp_first,
    output logic [DATA_W-1:0]            act_first,
    output logic                         failed
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
    localparam logic [CNT_W:0]   CNT_MAX  = {1'b0, {CNT_W{1'b1}}};
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_FAIL = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [OCC_W-1:0]  count_reg;
    logic [0:0]        state_reg;
    logic              err_overflow_reg;
    logic              err_underflow_reg;
    logic              err_data_reg;
    logic              err_flag_reg;
    logic [CNT_W-1:0]  err_count_reg;
    logic [DATA_W-1:0] exp_first_reg;
    logic [DATA_W-1:0] act_first_reg;

    logic              running;
    logic              is_full;
    logic              is_empty;
    logic              push;
    logic              pop;
    logic              bypass;
    logic [DATA_W-1:0] exp_word;
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_word;
    logic [3:0]        ev;
    logic [2:0]        ev_num;
    logic [CNT_W:0]    count_base;
    logic [CNT_W:0]    count_sum;
    logic [CNT_W-1:0]  err_count_next;

    assign running  = (state_reg == ST_RUN);
    assign is_full  = (count_reg == FULL_CNT);
    assign is_empty = (count_reg == '0);
    assign push     = vld_in && (!is_full || vld_out);
    assign pop      = vld_out && (!is_empty || vld_in);
    assign bypass   = is_empty && vld_in && vld_out;
    assign exp_word = bypass ? data_in : mem[rd_ptr_reg];

    // Where the data compare happens depends on when the DUT presents read data.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign cmp_valid = pop;
            assign cmp_word  = exp_word;
        end else begin : g_lat1
            logic              pend_reg;
            logic [DATA_W-1:0] pend_exp_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_reg     <= 1'b0;
                    pend_exp_reg <= '0;
                end else if (running) begin
                    pend_reg     <= pop;
                    pend_exp_reg <= exp_word;
                end
            end
            assign cmp_valid = pend_reg;
            assign cmp_word  = pend_exp_reg;
        end
    endgenerate

    assign ev[0] = running && vld_in && !vld_out && is_full;
    assign ev[1] = running && vld_out && !vld_in && is_empty;
    assign ev[2] = running && cmp_valid && (data_out != cmp_word);
    assign ev[3] = running && (CHECK_FLAGS != 0) &&
                   ((full_in != is_full) || (empty_in != is_empty));

    assign ev_num     = {2'b00, ev[0]} + {2'b00, ev[1]} + {2'b00, ev[2]} + {2'b00, ev[3]};
    assign count_base = clr_err ? '0 : {1'b0, err_count_reg};
    assign count_sum  = count_base + (CNT_W+1)'(ev_num);
    assign err_count_next = (count_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : count_sum[CNT_W-1:0];

    // Model storage carries no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (running && push && !bypass)
            mem[wr_ptr_reg] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            state_reg         <= ST_RUN;
            err_overflow_reg  <= 1'b0;
            err_underflow_reg <= 1'b0;
            err_data_reg      <= 1'b0;
            err_flag_reg      <= 1'b0;
            err_count_reg     <= '0;
            exp_first_reg     <= '0;
            act_first_reg     <= '0;
        end else begin
            if (running) begin
                if (push && !bypass)
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop && !bypass)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + OCC_W'(1);
                    2'b01:   count_reg <= count_reg - OCC_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
            if ((STOP_ON_ERR != 0) && (|ev))
                state_reg <= ST_FAIL;
            // A same-cycle event overrides clr_err.
            err_overflow_reg  <= (err_overflow_reg  && !clr_err) || ev[0];
            err_underflow_reg <= (err_underflow_reg && !clr_err) || ev[1];
            err_data_reg      <= (err_data_reg      && !clr_err) || ev[2];
            err_flag_reg      <= (err_flag_reg      && !clr_err) || ev[3];
            err_count_reg     <= err_count_next;
            if (ev[2] && (!err_data_reg || clr_err)) begin
                exp_first_reg <= cmp_word;
                act_first_reg <= data_out;
            end
        end
    end

    assign occupancy     = count_reg;
    assign err_overflow  = err_overflow_reg;
    assign err_underflow = err_underflow_reg;
    assign err_data      = err_data_reg;
    assign err_flag      = err_flag_reg;
    assign err_count     = err_count_reg;
    assign exp_first     = exp_first_reg;
    assign act_first     = act_first_reg;
    assign failed        = (state_reg == ST_FAIL);

endmodule

// File: tb/tb_fifo_scoreboard_param.sv
// Bench for fifo_scoreboard_param: directed plan plus random traffic checked
// against a queue-based model; a second instance exercises stop-on-error.
module tb_fifo_scoreboard_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld_in = 1'b0, vld_out = 1'b0, full_in = 1'b0, empty_in = 1'b1, clr_err = 1'b0;
    logic [3:0] data_in = '0, data_out = '0;
    logic [2:0] occupancy;
    logic       err_overflow, err_underflow, err_data, err_flag, failed;
    logic [7:0] err_count;
    logic [3:0] exp_first, act_first;

    logic       s_vld_in = 1'b0, s_vld_out = 1'b0, s_full_in = 1'b0, s_empty_in = 1'b1, s_clr_err = 1'b0;
    logic [3:0] s_data_in = '0, s_data_out = '0;
    logic [2:0] s_occupancy;
    logic       s_err_overflow, s_err_underflow, s_err_data, s_err_flag, s_failed;
    logic [7:0] s_err_count;
    logic [3:0] s_exp_first, s_act_first;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [3:0] q[$];
    bit         m_pend = 0;
    logic [3:0] m_pexp = '0;
    bit         m_ovf = 0, m_udf = 0, m_data = 0, m_flag = 0;
    int         m_cnt = 0;
    logic [3:0] m_exp_first = '0, m_act_first = '0;

    always #5 clk = ~clk;

    fifo_scoreboard_param dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .vld_out(vld_out),
        .data_out(data_out), .full_in(full_in), .empty_in(empty_in), .clr_err(clr_err),
        .occupancy(occupancy), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_data(err_data), .err_flag(err_flag), .err_count(err_count),
        .exp_first(exp_first), .act_first(act_first), .failed(failed)
    );

    fifo_scoreboard_param #(.STOP_ON_ERR(1)) sdut (
        .clk(clk), .rst(rst), .vld_in(s_vld_in), .data_in(s_data_in), .vld_out(s_vld_out),
        .data_out(s_data_out), .full_in(s_full_in), .empty_in(s_empty_in), .clr_err(s_clr_err),
        .occupancy(s_occupancy), .err_overflow(s_err_overflow), .err_underflow(s_err_underflow),
        .err_data(s_err_data), .err_flag(s_err_flag), .err_count(s_err_count),
        .exp_first(s_exp_first), .act_first(s_act_first), .failed(s_failed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_pexp = '0;
        m_ovf = 0; m_udf = 0; m_data = 0; m_flag = 0; m_cnt = 0;
        m_exp_first = '0; m_act_first = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".occ"},   32'(occupancy),     32'(q.size()));
        check({tag, ".ovf"},   32'(err_overflow),  32'(m_ovf));
        check({tag, ".udf"},   32'(err_underflow), 32'(m_udf));
        check({tag, ".data"},  32'(err_data),      32'(m_data));
        check({tag, ".flag"},  32'(err_flag),      32'(m_flag));
        check({tag, ".cnt"},   32'(err_count),     32'(m_cnt));
        check({tag, ".expf"},  32'(exp_first),     32'(m_exp_first));
        check({tag, ".actf"},  32'(act_first),     32'(m_act_first));
        check({tag, ".failed"}, 32'(failed),       32'd0);
    endtask

    // One clock of traffic on the main instance, model update, then full check.
    task automatic step(input string tag, input logic vi, input logic [3:0] di, input logic vo,
                        input logic [3:0] dout, input logic fi, input logic ei, input logic ce);
        int  n, ne;
        bit  ovf, udf, dev, fev, popping;
        vld_in = vi; data_in = di; vld_out = vo; data_out = dout;
        full_in = fi; empty_in = ei; clr_err = ce;
        n   = q.size();
        ovf = vi && !vo && (n == 4);
        udf = vo && !vi && (n == 0);
        dev = m_pend && (dout !== m_pexp);
        fev = (fi != (n == 4)) || (ei != (n == 0));
        ne  = int'(ovf) + int'(udf) + int'(dev) + int'(fev);
        if (dev && (ce || !m_data)) begin
            m_exp_first = m_pexp;
            m_act_first = dout;
        end
        m_ovf  = (m_ovf  && !ce) || ovf;
        m_udf  = (m_udf  && !ce) || udf;
        m_data = (m_data && !ce) || dev;
        m_flag = (m_flag && !ce) || fev;
        m_cnt  = (ce ? 0 : m_cnt) + ne;
        if (m_cnt > 255) m_cnt = 255;
        if (vi && vo && n == 0) begin
            m_pend = 1; m_pexp = di;
        end else begin
            popping = vo && (n > 0);
            if (popping) m_pexp = q.pop_front();
            m_pend = popping;
            if (vi && (n < 4 || vo)) q.push_back(di);
        end
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic wr(input logic [3:0] d);
        step("wr", 1'b1, d, 1'b0, m_pexp, q.size() == 4, q.size() == 0, 1'b0);
    endtask
    task automatic rd();
        step("rd", 1'b0, 4'h0, 1'b1, m_pexp, q.size() == 4, q.size() == 0, 1'b0);
    endtask
    task automatic idle(input logic [3:0] dout, input logic ce);
        step("idle", 1'b0, 4'h0, 1'b0, dout, q.size() == 4, q.size() == 0, ce);
    endtask

    task automatic sstep(input logic vi, input logic [3:0] di, input logic vo,
                         input logic [3:0] dout, input logic fi, input logic ei, input logic ce);
        s_vld_in = vi; s_data_in = di; s_vld_out = vo; s_data_out = dout;
        s_full_in = fi; s_empty_in = ei; s_clr_err = ce;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.s_failed", 32'(s_failed), 32'd0);
        rst = 1'b0;

        // In-order traffic, RD_LAT=1
        for (int i = 1; i <= 4; i++) wr(4'(i));
        check("p1.occ_full", 32'(occupancy), 32'd4);
        for (int i = 0; i < 4; i++) rd();
        idle(m_pexp, 1'b0);
        check("p1.occ_empty", 32'(occupancy), 32'd0);
        check("p1.cnt", 32'(err_count), 32'd0);

        // Overflow, then read+write at full
        for (int i = 0; i < 4; i++) wr(4'(i + 8));
        step("ovf", 1'b1, 4'h9, 1'b0, m_pexp, 1'b1, 1'b0, 1'b0);
        check("p2.ovf", 32'(err_overflow), 32'd1);
        check("p2.cnt", 32'(err_count), 32'd1);
        check("p2.occ", 32'(occupancy), 32'd4);
        step("rw_full", 1'b1, 4'h3, 1'b1, m_pexp, 1'b1, 1'b0, 1'b0);
        check("p2.rw_cnt", 32'(err_count), 32'd1);
        for (int i = 0; i < 4; i++) rd();
        idle(m_pexp, 1'b1);

        // Underflow and bypass at empty
        step("udf", 1'b0, 4'h0, 1'b1, m_pexp, 1'b0, 1'b1, 1'b0);
        check("p3.udf", 32'(err_underflow), 32'd1);
        idle(m_pexp, 1'b1);
        step("bypass", 1'b1, 4'hA, 1'b1, m_pexp, 1'b0, 1'b1, 1'b0);
        step("bypass_dat", 1'b0, 4'h0, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0);
        check("p3.cnt", 32'(err_count), 32'd0);
        check("p3.occ", 32'(occupancy), 32'd0);

        // Data mismatches: first one is captured
        wr(4'h5); rd(); idle(4'h6, 1'b0);
        wr(4'h7); rd(); idle(4'h0, 1'b0);
        check("p4.data", 32'(err_data), 32'd1);
        check("p4.expf", 32'(exp_first), 32'h5);
        check("p4.actf", 32'(act_first), 32'h6);
        check("p4.cnt", 32'(err_count), 32'd2);
        idle(m_pexp, 1'b1);

        // Wrong full flag at occupancy 2, clr_err while it persists
        wr(4'h1); wr(4'h2);
        for (int i = 0; i < 3; i++) step("flag", 1'b0, 4'h0, 1'b0, m_pexp, 1'b1, 1'b0, 1'b0);
        check("p5.cnt3", 32'(err_count), 32'd3);
        step("flag_clr", 1'b0, 4'h0, 1'b0, m_pexp, 1'b1, 1'b0, 1'b1);
        check("p5.flag", 32'(err_flag), 32'd1);
        check("p5.cnt1", 32'(err_count), 32'd1);

        // Counter saturation
        for (int i = 0; i < 260; i++) step("sat", 1'b0, 4'h0, 1'b0, m_pexp, 1'b1, 1'b0, 1'b0);
        check("sat.cnt", 32'(err_count), 32'd255);
        idle(m_pexp, 1'b1);
        rd(); rd(); idle(m_pexp, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic vi, vo, fi, ei, ce;
            logic [3:0] di, dout;
            vi   = ($urandom_range(0, 99) < 55);
            vo   = ($urandom_range(0, 99) < 50);
            di   = 4'($urandom_range(0, 15));
            dout = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : m_pexp;
            fi   = (q.size() == 4) ^ ($urandom_range(0, 19) == 0);
            ei   = (q.size() == 0) ^ ($urandom_range(0, 19) == 0);
            ce   = ($urandom_range(0, 29) == 0);
            step("rand", vi, di, vo, dout, fi, ei, ce);
        end

        // Async reset with a compare pending
        idle(m_pexp, 1'b1);
        while (q.size() != 0) rd();
        wr(4'h3); rd();
        rst = 1'b1;
        model_reset();
        #2;
        check_all("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst", 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        check("rst_mid.data", 32'(err_data), 32'd0);

        // Stop-on-error instance
        for (int i = 0; i < 4; i++) sstep(1'b1, 4'(i + 1), 1'b0, 4'h0, 1'b0, i == 0, 1'b0);
        check("s.occ4", 32'(s_occupancy), 32'd4);
        check("s.failed0", 32'(s_failed), 32'd0);
        sstep(1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("s.failed1", 32'(s_failed), 32'd1);
        check("s.ovf", 32'(s_err_overflow), 32'd1);
        check("s.cnt1", 32'(s_err_count), 32'd1);
        sstep(1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        check("s.frozen_rd", 32'(s_occupancy), 32'd4);
        check("s.ignored_cnt", 32'(s_err_count), 32'd1);
        check("s.ignored_flag", 32'(s_err_flag), 32'd0);
        sstep(1'b1, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        check("s.frozen_rw", 32'(s_occupancy), 32'd4);
        sstep(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        check("s.clr_ovf", 32'(s_err_overflow), 32'd0);
        check("s.clr_cnt", 32'(s_err_count), 32'd0);
        check("s.clr_failed", 32'(s_failed), 32'd1);
        rst = 1'b1;
        #2;
        check("s.rst_failed", 32'(s_failed), 32'd0);
        check("s.rst_occ", 32'(s_occupancy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sstep(1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        sstep(1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("s.rst2_occ", 32'(s_occupancy), 32'd0);
        check("s.rst2_cnt", 32'(s_err_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sstep(1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        check("s.post_rst_data", 32'(s_err_data), 32'd0);
        check("s.post_rst_cnt", 32'(s_err_count), 32'd0);
        check("s.post_rst_failed", 32'(s_failed), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
